// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execute stage and the ALU that is attached
// to it one level up: default widths, the opcode map (low 5 bits of the
// opcode byte) and the bit positions inside the 8-bit flag byte.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int BITS_DEFAULT = 8;
  localparam int RD_W_DEFAULT = 3;
  localparam int FLAGS_W      = 8;

  // Opcode map. Only the low 5 bits of the opcode byte are significant.
  // The execute stage never decodes these; they exist so the ALU and its
  // users agree on the encoding.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_AND  = 5'd5,
    OP_OR   = 5'd6,
    OP_XOR  = 5'd7,
    OP_NOT  = 5'd8,
    OP_NAND = 5'd9,
    OP_NOR  = 5'd10,
    OP_XNOR = 5'd11,
    OP_CMP  = 5'd12,
    OP_SHR  = 5'd13,
    OP_SHL  = 5'd14
  } alu_opcode_e;

  // Flag byte bit positions.
  localparam int FLAG_OVF     = 0;
  localparam int FLAG_UNF     = 1;
  localparam int FLAG_GT      = 2;
  localparam int FLAG_EQ      = 3;
  localparam int FLAG_DIV0    = 4;
  localparam int FLAG_UNKNOWN = 5;

  // True when the low 5 bits of an opcode byte name a defined operation.
  function automatic logic is_known_op(input logic [4:0] op);
    return op <= OP_SHL;
  endfunction

endpackage

// File: rtl/alu_exec_slice.sv
// -----------------------------------------------------------------------------
// exec_slice
// Generic one-entry valid/ready register slice. Accepts a word whenever it is
// empty or its current word is leaving downstream in the same cycle, so a
// chain of slices sustains one transfer per clock.
//
// Parameters
//   W          data width
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset (clears valid and data)
//   in_valid   upstream offers in_data
//   in_ready   slice can take a word this cycle (combinational)
//   in_data    upstream word
//   out_valid  slice holds a word
//   out_ready  downstream takes the held word this cycle
//   out_data   held word
// -----------------------------------------------------------------------------
module exec_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         load;

  // Ready depends only on our own state and downstream ready, never on
  // in_valid, so no combinational loop forms across the handshake.
  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: state is written with non-blocking assignments so every register
  // in the stage samples the pre-edge values, independent of block order.
  // NOTE: the data register is reset too (not just the valid bit) so the
  // outputs read as zero after reset rather than holding stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= load || (valid_q && !out_ready);
      if (load) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Two-slice execute stage wrapped around an external combinational ALU.
// The operand slice (OP) holds an issued op and drives the ALU; when the
// result slice (RES) can take it, the ALU output plus the destination index
// move into RES and are presented on the writeback handshake.
//
// Build option
//   ALU_STICKY_FLAGS_EN  defined: flags_q accumulates (OR) flags until
//                        flags_clr; undefined: flags_q mirrors the flags of
//                        the last op that moved into RES.
//
// Parameters
//   BITS       operand/result width
//   RD_W       destination register index width
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   in_valid/in_ready        issue handshake
//   in_op/in_a/in_b/in_rd    opcode byte, operands, destination index
//   alu_op/alu_a/alu_b       drive the external ALU (zero while OP is empty)
//   alu_z/alu_flags          external ALU result and flag byte
//   out_valid/out_ready      writeback handshake
//   out_z/out_rd/out_flags   retired result, destination, flags
//   flags_q                  architectural flag register
//   flags_clr                synchronous clear of flags_q
//   retired                  results accepted downstream (wraps at 16 bits)
// -----------------------------------------------------------------------------
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT,
  parameter int RD_W = RD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITS-1:0]    in_op,
  input  logic [BITS-1:0]    in_a,
  input  logic [BITS-1:0]    in_b,
  input  logic [RD_W-1:0]    in_rd,
  output logic [BITS-1:0]    alu_op,
  output logic [BITS-1:0]    alu_a,
  output logic [BITS-1:0]    alu_b,
  input  logic [BITS-1:0]    alu_z,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    out_z,
  output logic [RD_W-1:0]    out_rd,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [FLAGS_W-1:0] flags_q,
  input  logic               flags_clr,
  output logic [15:0]        retired
);

  localparam int OP_W  = 3 * BITS + RD_W;
  localparam int RES_W = BITS + FLAGS_W + RD_W;

  logic               op_valid;
  logic               op_in_ready;
  logic               res_in_ready;
  logic               adv;
  logic [OP_W-1:0]    op_data;
  logic [BITS-1:0]    op_code_q;
  logic [BITS-1:0]    op_a_q;
  logic [BITS-1:0]    op_b_q;
  logic [RD_W-1:0]    op_rd_q;
  logic [RES_W-1:0]   res_data;
  logic [FLAGS_W-1:0] flags_base;
  logic [FLAGS_W-1:0] flags_next;

  // ---------------------------------------------------------------------------
  // Operand slice: drains into RES whenever RES is empty or retiring.
  // ---------------------------------------------------------------------------
  exec_slice #(.W(OP_W)) u_op_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (op_in_ready),
    .in_data   ({in_op, in_a, in_b, in_rd}),
    .out_valid (op_valid),
    .out_ready (res_in_ready),
    .out_data  (op_data)
  );

  assign {op_code_q, op_a_q, op_b_q, op_rd_q} = op_data;

  // res_in_ready is !RES.valid || out_ready, so this is the advance condition
  // and in_ready reduces to !OP.valid || adv.
  assign adv      = op_valid && res_in_ready;
  assign in_ready = op_in_ready;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (op_valid) begin
      alu_op = op_code_q;
      alu_a  = op_a_q;
      alu_b  = op_b_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Result slice: captures the ALU output and the carried destination on adv.
  // ---------------------------------------------------------------------------
  exec_slice #(.W(RES_W)) u_res_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (op_valid),
    .in_ready  (res_in_ready),
    .in_data   ({alu_z, alu_flags, op_rd_q}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res_data)
  );

  assign {out_z, out_flags, out_rd} = res_data;

  // ---------------------------------------------------------------------------
  // Architectural flags. A clear takes effect first; an advance in the same
  // cycle then applies its flags on top of the cleared value.
  // ---------------------------------------------------------------------------
  always_comb begin
    flags_base = flags_clr ? '0 : flags_q;
    flags_next = flags_base;
    if (adv) begin
`ifdef ALU_STICKY_FLAGS_EN
      flags_next = flags_base | alu_flags;
`else
      flags_next = alu_flags;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_next;
    end
  end

  // Retirement counter; natural 16-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (out_valid && out_ready) begin
      retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
// Directed bench for alu_exec_stage. The bench acts as the level above: it
// supplies a small combinational ALU on alu_op/alu_a/alu_b. Each issued op
// carries a hand-computed expected result that is queued on acceptance and
// compared when the op retires on the writeback handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_exec_stage;
  import alu_pkg::*;

`ifdef ALU_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_op, in_a, in_b;
  logic [2:0] in_rd;
  logic [7:0] alu_op, alu_a, alu_b;
  logic [7:0] alu_z, alu_flags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_z;
  logic [2:0] out_rd;
  logic [7:0] out_flags;
  logic [7:0] flags_q;
  logic       flags_clr;
  logic [15:0] retired;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rd     (in_rd),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_z     (alu_z),
    .alu_flags (alu_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_rd    (out_rd),
    .out_flags (out_flags),
    .flags_q   (flags_q),
    .flags_clr (flags_clr),
    .retired   (retired)
  );

  // ---------------------------------------------------------------------------
  // External ALU
  // ---------------------------------------------------------------------------
  logic [8:0] wide;
  always_comb begin
    alu_z     = '0;
    alu_flags = '0;
    wide      = '0;
    case (alu_op[4:0])
      OP_ADD: begin
        wide                = {1'b0, alu_a} + {1'b0, alu_b};
        alu_z               = wide[7:0];
        alu_flags[FLAG_OVF] = wide[8];
      end
      OP_SUB: begin
        alu_z               = alu_a - alu_b;
        alu_flags[FLAG_UNF] = alu_a < alu_b;
      end
      OP_DIV: begin
        if (alu_b == 8'd0) alu_flags[FLAG_DIV0] = 1'b1;
        else               alu_z = alu_a / alu_b;
      end
      OP_AND: alu_z = alu_a & alu_b;
      OP_OR:  alu_z = alu_a | alu_b;
      OP_XOR: alu_z = alu_a ^ alu_b;
      OP_CMP: begin
        alu_flags[FLAG_GT] = alu_a > alu_b;
        alu_flags[FLAG_EQ] = alu_a == alu_b;
      end
      OP_SHL: alu_z = alu_a << alu_b[2:0];
      OP_SHR: alu_z = alu_a >> alu_b[2:0];
      default: begin
        if (!is_known_op(alu_op[4:0])) alu_flags[FLAG_UNKNOWN] = 1'b1;
        else                           alu_z = alu_a;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Check bookkeeping and scoreboard
  // ---------------------------------------------------------------------------
  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  typedef struct {
    logic [7:0] z;
    logic [7:0] f;
    logic [2:0] rd;
  } exp_t;

  exp_t       sb_q[$];
  bit         sb_en = 1'b1;
  logic [7:0] drv_z, drv_f;

  // Stall-stability snapshot
  bit         stalled_prev = 1'b0;
  logic [7:0] snap_z, snap_f;
  logic [2:0] snap_rd;

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (sb_en && in_valid && in_ready)
        sb_q.push_back('{z: drv_z, f: drv_f, rd: in_rd});
      if (sb_en && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", 32'(sb_q.size()), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_z",     32'(out_z),     32'(e.z));
          check("out_flags", 32'(out_flags), 32'(e.f));
          check("out_rd",    32'(out_rd),    32'(e.rd));
        end
      end
      if (out_valid && !out_ready) begin
        if (stalled_prev) begin
          check("stall_z",     32'(out_z),     32'(snap_z));
          check("stall_flags", 32'(out_flags), 32'(snap_f));
          check("stall_rd",    32'(out_rd),    32'(snap_rd));
        end
        snap_z       = out_z;
        snap_f       = out_flags;
        snap_rd      = out_rd;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one op and returns one ns after the edge that accepted it.
  task automatic issue(input int op, input int a, input int b, input int rd,
                       input int ez, input int ef, output int waits);
    bit got;
    got      = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_op    = 8'(op);
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_rd    = 3'(rd);
    drv_z    = 8'(ez);
    drv_f    = 8'(ef);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    if (!got) check("issue_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      tick();
    end
    check(tag, 32'(sb_q.size()) + 32'(out_valid), 0);
  endtask

  // Global time limit
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w, w2, w3, w4, acc;
    bit reached;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_rd     = '0;
    out_ready = 1'b1;
    flags_clr = 1'b0;
    drv_z     = '0;
    drv_f     = '0;

    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;

    // Reset state, first cycle after release
    check("post_rst_in_ready",  32'(in_ready),  1);
    check("post_rst_out_valid", 32'(out_valid), 0);
    check("post_rst_retired",   32'(retired),   0);
    check("post_rst_flags",     32'(flags_q),   0);
    check("post_rst_alu_op",    32'(alu_op),    0);

    // ADD 200+100: accepted, driven to ALU, result one edge later
    issue(OP_ADD, 200, 100, 1, 44, 8'h01, w);
    check("add_alu_op",     32'(alu_op),    32'(OP_ADD));
    check("add_alu_a",      32'(alu_a),     200);
    check("add_alu_b",      32'(alu_b),     100);
    check("add_not_yet",    32'(out_valid), 0);
    tick();
    check("add_out_valid",  32'(out_valid), 1);
    check("add_out_z",      32'(out_z),     44);
    check("add_out_flags",  32'(out_flags), 8'h01);
    check("add_flags_q",    32'(flags_q),   8'h01);
    tick();
    check("add_retired_gone", 32'(out_valid), 0);
    check("add_retired",      32'(retired),   1);
    check("op_empty_alu_a",   32'(alu_a),     0);

    // Clear, then DIV by zero
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("clr_flags_q", 32'(flags_q), 0);
    issue(OP_DIV, 9, 0, 2, 0, 8'h10, w);
    drain("div_drain");
    check("div_flags_q", 32'(flags_q), 8'h10);

    // Sustained throughput, including an unknown opcode
    issue(OP_CMP, 9, 3, 3, 0, 8'h04, w);
    issue(8'hFF, 1, 2, 4, 0, 8'h20, w2);
    issue(OP_SHL, 8'h81, 1, 5, 8'h02, 0, w3);
    issue(OP_XOR, 8'h3C, 8'hFF, 6, 8'hC3, 0, w4);
    check("thru_waits", 32'(w2 + w3 + w4), 0);
    drain("thru_drain");
    check("unknown_flags_q", 32'(flags_q), STICKY ? 8'h34 : 8'h00);

    // Backpressure: two accepted, third held off until release
    out_ready = 1'b0;
    issue(OP_SUB, 50, 20, 3, 30, 0, w);
    issue(OP_OR, 8'hA0, 8'h05, 4, 8'hA5, 0, w);
    check("stall_in_ready", 32'(in_ready), 0);
    fork
      issue(OP_XOR, 8'hFF, 8'h0F, 5, 8'hF0, 0, w);
      begin
        repeat (3) tick();
        check("stall_in_ready_held", 32'(in_ready), 0);
        check("stall_head_z",        32'(out_z),    30);
        check("stall_head_rd",       32'(out_rd),   3);
        out_ready = 1'b1;
      end
    join
    drain("stall_drain");

    // Sticky vs. last-op flags
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    issue(OP_ADD, 8'hF0, 8'h20, 6, 8'h10, 8'h01, w);
    issue(OP_AND, 8'h0F, 8'h03, 7, 8'h03, 8'h00, w);
    drain("flags_drain1");
    check("flags_after_and", 32'(flags_q), STICKY ? 8'h01 : 8'h00);
    issue(OP_DIV, 5, 0, 1, 0, 8'h10, w);
    drain("flags_drain2");
    check("flags_after_div", 32'(flags_q), STICKY ? 8'h11 : 8'h10);
    // Clear coincides with the advance of an overflowing ADD
    issue(OP_ADD, 8'h80, 8'h80, 2, 8'h00, 8'h01, w);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("clr_with_adv", 32'(flags_q), 8'h01);
    drain("flags_drain3");

    // Reset with both slices occupied
    out_ready = 1'b0;
    issue(OP_SUB, 9, 4, 1, 5, 0, w);
    issue(OP_ADD, 1, 2, 2, 3, 0, w);
    check("pre_rst_out_valid", 32'(out_valid), 1);
    check("pre_rst_in_ready",  32'(in_ready),  0);
    rst = 1'b1;
    #1;
    check("rst_now_out_valid", 32'(out_valid), 0);
    check("rst_now_retired",   32'(retired),   0);
    check("rst_now_flags",     32'(flags_q),   0);
    check("rst_now_alu_a",     32'(alu_a),     0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    check("rst_rel_in_ready",  32'(in_ready),  1);
    check("rst_rel_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    issue(OP_CMP, 7, 7, 5, 0, 8'h08, w);
    drain("rst_drain");
    check("rst_next_retired", 32'(retired), 1);
    check("rst_next_flags",   32'(flags_q), 8'h08);

    // Counter wrap: 65535 more retirements take 1 -> 0x0000
    sb_en    = 1'b0;
    in_op    = 8'(OP_ADD);
    in_a     = '0;
    in_b     = '0;
    in_rd    = '0;
    in_valid = 1'b1;
    acc      = 0;
    reached  = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      if (acc == 65535) begin
        reached = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("wrap_accepts", 32'(reached), 1);
    tick();
    check("wrap_near", 32'(retired), 16'hFFFF);
    tick();
    check("wrap_zero",  32'(retired),   16'h0000);
    check("wrap_idle",  32'(out_valid), 0);
    sb_en = 1'b1;

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
